hazard_ctrl: RTL and testbench

//  Pipeline hazard controller for the 5-stage RV32I core. Drives stall/flush enables of the
//  F/D, D/E, E/M and M/W registers, and selects E-stage operand forwarding. It sequences load-use

---
 rtl/hazard_ctrl.sv | 149 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush sequencing, operand forwarding and hazard counters
// for the 5-stage pipeline: load-use bubbles, branch redirects, data-memory freezes.
module hazard_ctrl #(
  parameter int REDIRECT_CYC = 1,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       RS1_D,
  input  logic [4:0]       RS2_D,
  input  logic [4:0]       RS1_E,
  input  logic [4:0]       RS2_E,
  input  logic [4:0]       RD_E,
  input  logic             ResultSrcE,
  input  logic             PCSrcE,
  input  logic [4:0]       RD_M,
  input  logic             RegWriteM,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  input  logic [4:0]       RD_W,
  input  logic             RegWriteW,
  input  logic             cnt_clr,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_err
);

  localparam int TW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(MEM_TIMEOUT);
  localparam logic [3:0]    RCYC = 4'(REDIRECT_CYC);

  typedef enum logic [1:0] {RUN, REDIRECT, MEM_WAIT} state_t;

  state_t           state_q, state_d, ret_q, ret_d, eff_state;
  logic [3:0]       rcnt_q, rcnt_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic             lu, memwait;

  always_comb begin
    ForwardAE = 2'b00;
    if (RegWriteM && RD_M != 5'd0 && RD_M == RS1_E)      ForwardAE = 2'b10;
    else if (RegWriteW && RD_W != 5'd0 && RD_W == RS1_E) ForwardAE = 2'b01;
    ForwardBE = 2'b00;
    if (RegWriteM && RD_M != 5'd0 && RD_M == RS2_E)      ForwardBE = 2'b10;
    else if (RegWriteW && RD_W != 5'd0 && RD_W == RS2_E) ForwardBE = 2'b01;
  end

  assign lu      = ResultSrcE && RD_E != 5'd0 && (RD_E == RS1_D || RD_E == RS2_D);
  assign memwait = MemReqM && !MemReadyM;
  // The ready cycle that ends a wait behaves as whichever state was frozen.
  assign eff_state = (state_q == MEM_WAIT) ? ret_q : state_q;

  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    state_d   = state_q;
    ret_d     = ret_q;
    rcnt_d    = rcnt_q;
    tcnt_d    = '0;
    mem_err_d = mem_err_q;
    if (rst) begin
      if (memwait) begin
        StallF  = 1'b1;
        StallD  = 1'b1;
        StallE  = 1'b1;
        StallM  = 1'b1;
        FlushW  = 1'b1;
        state_d = MEM_WAIT;
        if (state_q != MEM_WAIT) ret_d = state_q;
        tcnt_d = (tcnt_q != TMAX) ? tcnt_q + TW'(1) : tcnt_q;
        if (tcnt_d == TMAX) mem_err_d = 1'b1;
      end else if (PCSrcE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
        if (REDIRECT_CYC > 0) begin
          state_d = REDIRECT;
          rcnt_d  = RCYC;
        end else begin
          state_d = RUN;
        end
      end else if (eff_state == REDIRECT) begin
        FlushD  = 1'b1;
        rcnt_d  = (rcnt_q != 4'd0) ? rcnt_q - 4'd1 : 4'd0;
        state_d = (rcnt_q <= 4'd1) ? RUN : REDIRECT;
      end else begin
        state_d = RUN;
        if (lu) begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
        end
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (StallF && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (FlushE && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      ret_q       <= RUN;
      rcnt_q      <= '0;
      tcnt_q      <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      rcnt_q      <= rcnt_d;
      tcnt_q      <= tcnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign mem_err   = mem_err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed bench for hazard_ctrl (REDIRECT_CYC=2, MEM_TIMEOUT=8).
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W;
  logic        ResultSrcE, PCSrcE, RegWriteM, MemReqM, MemReadyM, RegWriteW, cnt_clr;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_err;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] stall_cnt, flush_cnt;
  logic [6:0]  flags;
  int          total = 0;
  int          bad = 0;

  // flag order: StallF StallD StallE StallM FlushD FlushE FlushW
  localparam logic [6:0] F_NONE   = 7'b0000000;
  localparam logic [6:0] F_LU     = 7'b1100010;
  localparam logic [6:0] F_BR     = 7'b0000110;
  localparam logic [6:0] F_RDIR   = 7'b0000100;
  localparam logic [6:0] F_FREEZE = 7'b1111001;

  hazard_ctrl #(.REDIRECT_CYC(2), .MEM_TIMEOUT(8), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .RS1_D(RS1_D), .RS2_D(RS2_D), .RS1_E(RS1_E), .RS2_E(RS2_E), .RD_E(RD_E),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .RD_M(RD_M), .RegWriteM(RegWriteM),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM), .RD_W(RD_W), .RegWriteW(RegWriteW),
    .cnt_clr(cnt_clr),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_err(mem_err)
  );

  always #5 clk = ~clk;
  assign flags = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    {RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W} = '0;
    {ResultSrcE, PCSrcE, RegWriteM, MemReqM, MemReadyM, RegWriteW, cnt_clr} = '0;
    #2;
    chk("reset_flags", 32'(flags), 32'(F_NONE));
    chk("reset_stall_cnt", stall_cnt, 0);
    chk("reset_flush_cnt", flush_cnt, 0);
    chk("reset_mem_err", 32'(mem_err), 0);
    tick();
    rst = 1'b1;

    // forwarding priority
    RegWriteM = 1; RD_M = 5; RegWriteW = 1; RD_W = 5; RS1_E = 5; RS2_E = 5; #1;
    chk("fwd_a_m", 32'(ForwardAE), 2);
    chk("fwd_b_m", 32'(ForwardBE), 2);
    RD_M = 0; #1;
    chk("fwd_a_w", 32'(ForwardAE), 1);
    RD_W = 0; #1;
    chk("fwd_a_none", 32'(ForwardAE), 0);
    RD_W = 3; RS2_E = 3; #1;
    chk("fwd_b_w", 32'(ForwardBE), 1);
    chk("fwd_a_mismatch", 32'(ForwardAE), 0);
    RegWriteW = 0; #1;
    chk("fwd_b_nowrite", 32'(ForwardBE), 0);
    {RegWriteM, RegWriteW, RD_M, RD_W, RS1_E, RS2_E} = '0;

    // load-use bubble
    ResultSrcE = 1; RD_E = 7; RS2_D = 7; #1;
    chk("lu_flags", 32'(flags), 32'(F_LU));
    tick();
    ResultSrcE = 0; #1;
    chk("lu_after", 32'(flags), 32'(F_NONE));
    chk("lu_stall_cnt", stall_cnt, 1);
    chk("lu_flush_cnt", flush_cnt, 1);
    ResultSrcE = 1; RD_E = 0; RS2_D = 0; #1;
    chk("lu_rd0", 32'(flags), 32'(F_NONE));
    tick();
    chk("lu_rd0_cnt", stall_cnt, 1);

    // branch beats load-use, then two redirect cycles
    RD_E = 7; RS2_D = 7; PCSrcE = 1; #1;
    chk("br_flags", 32'(flags), 32'(F_BR));
    tick();
    PCSrcE = 0; #1;
    chk("rdir1", 32'(flags), 32'(F_RDIR));
    tick();
    chk("rdir2", 32'(flags), 32'(F_RDIR));
    tick();
    chk("rdir_done_run_lu", 32'(flags), 32'(F_LU));
    ResultSrcE = 0; RD_E = 0; RS2_D = 0; #1;
    chk("br_stall_cnt", stall_cnt, 1);
    chk("br_flush_cnt", flush_cnt, 2);

    // memory freeze with a pending branch
    MemReqM = 1; MemReadyM = 0; PCSrcE = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("freeze%0d", i), 32'(flags), 32'(F_FREEZE));
      tick();
    end
    MemReadyM = 1; #1;
    chk("ready_branch", 32'(flags), 32'(F_BR));
    tick();
    MemReqM = 0; MemReadyM = 0; PCSrcE = 0; #1;
    chk("mw_rdir1", 32'(flags), 32'(F_RDIR));
    tick();
    chk("mw_rdir2", 32'(flags), 32'(F_RDIR));
    tick();
    chk("mw_run", 32'(flags), 32'(F_NONE));
    chk("mw_stall_cnt", stall_cnt, 5);
    chk("mw_flush_cnt", flush_cnt, 3);
    chk("mw_no_err", 32'(mem_err), 0);

    // timeout after 8 waiting cycles, waiting continues
    MemReqM = 1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk($sformatf("to_err%0d", k), 32'(mem_err), (k >= 8) ? 1 : 0);
      chk($sformatf("to_stall%0d", k), 32'(StallF), 1);
    end
    MemReadyM = 1; tick();
    MemReqM = 0; MemReadyM = 0; #1;
    chk("to_sticky", 32'(mem_err), 1);
    chk("to_flags", 32'(flags), 32'(F_NONE));
    chk("to_stall_cnt", stall_cnt, 15);

    // clear beats increment
    ResultSrcE = 1; RD_E = 4; RS1_D = 4; cnt_clr = 1; tick();
    cnt_clr = 0; ResultSrcE = 0; #1;
    chk("clr_stall", stall_cnt, 0);
    chk("clr_flush", flush_cnt, 0);

    // async reset mid-wait
    MemReqM = 1; tick(); tick();
    chk("pre_rst_cnt", stall_cnt, 2);
    #2 rst = 1'b0; #1;
    chk("arst_flags", 32'(flags), 32'(F_NONE));
    chk("arst_stall_cnt", stall_cnt, 0);
    chk("arst_mem_err", 32'(mem_err), 0);
    MemReqM = 0; #1 rst = 1'b1; #1;
    ResultSrcE = 1; #1;
    chk("arst_run_lu", 32'(flags), 32'(F_LU));
    ResultSrcE = 0;

    // async reset mid-redirect
    tick();
    PCSrcE = 1; tick();
    PCSrcE = 0; #1;
    chk("pre_rst_rdir", 32'(flags), 32'(F_RDIR));
    rst = 1'b0; #1;
    chk("arst2_flags", 32'(flags), 32'(F_NONE));
    rst = 1'b1; #1;
    chk("arst2_run", 32'(flags), 32'(F_NONE));
    tick();
    chk("arst2_still_run", 32'(flags), 32'(F_NONE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
